// File: rtl/swizzle_serializer_if.sv
// Handshake bundle for swizzle_serializer: the operand input stream and the 3-bit beat output stream.
interface swizzle_serializer_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] c;
   logic [2:0] d;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_data;
   logic       out_last;

   // Valid/ready: a transfer occurs on a rising clk edge where valid and ready are both high;
   // a sender never waits for ready before raising valid, and holds its payload stable until taken.
   modport master (
      output in_valid, c, d, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
   modport slave (
      input  in_valid, c, d, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/swizzle_serializer.sv
// swizzle_serializer: packs (c, d) into {c[2:1], {3{d[0]}}, c[0], TAG} and streams it as 3-bit beats.
// Define SWZ_PARITY_EN to append an even-parity fourth beat to every word.
module swizzle_serializer #(
   parameter logic [2:0] TAG       = 3'b101,
   parameter int         MSB_FIRST = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   swizzle_serializer_if.slave  bus,
   output logic                 busy,
   output logic                 state_o
);

`ifdef SWZ_PARITY_EN
   localparam logic [1:0] LAST_BEAT = 2'd3;
`else
   localparam logic [1:0] LAST_BEAT = 2'd2;
`endif

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

   state_e     state_q, state_d;
   logic [8:0] sr_q, sr_d;
   logic [8:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic [1:0] beat_q, beat_d;
   logic [8:0] word;
   logic [2:0] beat_data;
   logic       accept, fire, last_beat, last_fire;
   logic       unused_d;

   assign word      = {bus.c[2:1], {3{bus.d[0]}}, bus.c[0], TAG};
   assign unused_d  = ^bus.d[2:1];
   assign accept    = bus.in_valid && bus.in_ready;
   assign fire      = bus.out_valid && bus.out_ready;
   assign last_beat = (beat_q == LAST_BEAT);
   assign last_fire = fire && last_beat;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SEND;
         SEND:    if (last_fire && !hold_full_q && !accept) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // in_ready depends only on registered state and reset, never on out_ready.
   always_comb begin
      bus.out_valid = (state_q == SEND);
      bus.in_ready  = !hold_full_q && !reset;
      bus.out_last  = last_beat && (state_q == SEND);
      bus.out_data  = (state_q == SEND) ? beat_data : 3'b000;
      busy          = (state_q == SEND) || hold_full_q;
      state_o       = (state_q == SEND);
   end

   always_comb begin
      beat_data = 3'b000;
      case (beat_q)
         2'd0:    beat_data = (MSB_FIRST != 0) ? sr_q[8:6] : sr_q[2:0];
         2'd1:    beat_data = sr_q[5:3];
         2'd2:    beat_data = (MSB_FIRST != 0) ? sr_q[2:0] : sr_q[8:6];
`ifdef SWZ_PARITY_EN
         2'd3:    beat_data = {2'b00, ^sr_q};
`endif
         default: beat_data = 3'b000;
      endcase
   end

   // A new word bypasses the holding buffer when sr is free or frees up on this very edge.
   always_comb begin
      sr_d        = sr_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      beat_d      = beat_q;
      if (fire) begin
         if (!last_beat) begin
            beat_d = beat_q + 2'd1;
         end else begin
            beat_d = 2'd0;
            if (hold_full_q) begin
               sr_d        = hold_q;
               hold_full_d = 1'b0;
            end
         end
      end
      if (accept) begin
         if ((state_q == IDLE) || (last_fire && !hold_full_q)) begin
            sr_d   = word;
            beat_d = 2'd0;
         end else begin
            hold_d      = word;
            hold_full_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q        <= 9'd0;
         hold_q      <= 9'd0;
         hold_full_q <= 1'b0;
         beat_q      <= 2'd0;
      end else begin
         sr_q        <= sr_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         beat_q      <= beat_d;
      end
   end

endmodule

// File: tb/tb_swizzle_serializer.sv
// Bench for swizzle_serializer: MSB-first and LSB-first instances driven in lockstep,
// with a per-instance expected-beat queue checked on every output handshake.
module tb_swizzle_serializer;

`ifdef SWZ_PARITY_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic clk;
  logic reset;
  logic in_valid;
  logic [2:0] c;
  logic [2:0] d;
  logic out_ready;
  logic [8:0] cur_w;
  logic busy_m, busy_l, state_m, state_l;

  int n_vec = 0;
  int n_fail = 0;
  int n_sent = 0;
  int acc_m = 0;
  int acc_l = 0;

  logic [3:0] exp_m[$];
  logic [3:0] exp_l[$];

  swizzle_serializer_if bus_m ();
  swizzle_serializer_if bus_l ();

  assign bus_m.in_valid  = in_valid;
  assign bus_m.c         = c;
  assign bus_m.d         = d;
  assign bus_m.out_ready = out_ready;
  assign bus_l.in_valid  = in_valid;
  assign bus_l.c         = c;
  assign bus_l.d         = d;
  assign bus_l.out_ready = out_ready;

  swizzle_serializer #(.TAG(3'b101), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .bus(bus_m.slave), .busy(busy_m), .state_o(state_m)
  );
  swizzle_serializer #(.TAG(3'b101), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .bus(bus_l.slave), .busy(busy_l), .state_o(state_l)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_word(input bit msb, input logic [8:0] w);
    logic [2:0] b [4];
    b[0] = msb ? w[8:6] : w[2:0];
    b[1] = w[5:3];
    b[2] = msb ? w[2:0] : w[8:6];
    b[3] = {2'b00, ^w};
    for (int i = 0; i < NB; i++) begin
      if (msb) exp_m.push_back({(i == NB - 1), b[i]});
      else     exp_l.push_back({(i == NB - 1), b[i]});
    end
  endtask

  function automatic logic exp_rdy(input int j);
    return !(((j >= 2) && (j <= NB)) || ((j >= NB + 2) && (j <= 2 * NB)));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] cc, input logic [2:0] dd, input logic [8:0] w);
    int t;
    in_valid = 1'b1;
    c = cc;
    d = dd;
    cur_w = w;
    n_sent++;
    t = 0;
    @(negedge clk);
    while (!bus_m.in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy_m || busy_l) && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) chk("idle_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [3:0] e;
    if (!reset) begin
      if (in_valid && bus_m.in_ready) begin
        push_word(1'b1, cur_w);
        acc_m++;
      end
      if (in_valid && bus_l.in_ready) begin
        push_word(1'b0, cur_w);
        acc_l++;
      end
      if (bus_m.out_valid && out_ready) begin
        if (exp_m.size() == 0) chk("beat_m_unexpected", {28'd0, bus_m.out_last, bus_m.out_data}, 32'hffff);
        else begin
          e = exp_m.pop_front();
          chk("beat_m", {28'd0, bus_m.out_last, bus_m.out_data}, {28'd0, e});
        end
      end
      if (bus_l.out_valid && out_ready) begin
        if (exp_l.size() == 0) chk("beat_l_unexpected", {28'd0, bus_l.out_last, bus_l.out_data}, 32'hffff);
        else begin
          e = exp_l.pop_front();
          chk("beat_l", {28'd0, bus_l.out_last, bus_l.out_data}, {28'd0, e});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    in_valid = 1'b1;
    c = 3'b111;
    d = 3'b001;
    cur_w = 9'd0;
    out_ready = 1'b1;

    // reset: inputs offered during reset are ignored
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_m", bus_m.in_ready, 0);
    chk("rst_in_ready_l", bus_l.in_ready, 0);
    chk("rst_out_valid_in_reset", bus_m.out_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus_m.out_valid, 0);
    chk("rst_out_last", bus_m.out_last, 0);
    chk("rst_out_data", bus_m.out_data, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_state", state_m, 0);
    chk("rst_in_ready_after", bus_m.in_ready, 1);
    chk("rst_busy_l", busy_l, 0);
    @(posedge clk);
    #1;

    // single word, first beat in cycle k+1
    send(3'b110, 3'b001, 9'b111110101);
    @(negedge clk);
    chk("single_lat_valid", bus_m.out_valid, 1);
    chk("single_beat0_m", bus_m.out_data, 3'b111);
    chk("single_beat0_l", bus_l.out_data, 3'b101);
    wait_idle();

    // reverse order word
    send(3'b001, 3'b000, 9'b000001101);
    @(negedge clk);
    chk("rev_beat0_l", bus_l.out_data, 3'b101);
    chk("rev_beat0_m", bus_m.out_data, 3'b000);
    wait_idle();

    // back-to-back: three words, no bubbles, hold-release timing on in_ready
    fork
      begin
        send(3'b011, 3'b110, 9'b010001101);
        send(3'b100, 3'b011, 9'b101110101);
        send(3'b111, 3'b001, 9'b111111101);
      end
      begin
        int t;
        int nvalid;
        t = 0;
        nvalid = 0;
        @(negedge clk);
        while (!bus_m.out_valid && t < 20) begin
          t++;
          @(negedge clk);
        end
        for (int j = 1; j <= 3 * NB; j++) begin
          if (bus_m.out_valid && bus_l.out_valid) nvalid++;
          chk("b2b_in_ready", bus_m.in_ready, exp_rdy(j));
          @(negedge clk);
        end
        chk("b2b_valid_run", nvalid, 3 * NB);
        chk("b2b_gap_after", bus_m.out_valid, 0);
      end
    join
    wait_idle();

    // backpressure on beat1 with a second word filling hold
    send(3'b101, 3'b111, 9'b101111101);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(3'b010, 3'b100, 9'b010000101);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_data_m", bus_m.out_data, 3'b111);
      chk("bp_data_l", bus_l.out_data, 3'b111);
      chk("bp_last_m", bus_m.out_last, 0);
      chk("bp_in_ready", bus_m.in_ready, 0);
      chk("bp_busy", busy_m, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();

    // reset mid-word with a word held
    send(3'b110, 3'b001, 9'b111110101);
    send(3'b011, 3'b110, 9'b010001101);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_m.delete();
    exp_l.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", bus_m.out_valid, 0);
    chk("mid_rst_busy_m", busy_m, 0);
    chk("mid_rst_busy_l", busy_l, 0);
    chk("mid_rst_in_ready", bus_m.in_ready, 1);
    repeat (3) @(negedge clk);
    chk("mid_rst_quiet", bus_m.out_valid | bus_l.out_valid, 0);
    @(posedge clk);
    #1;
    send(3'b111, 3'b001, 9'b111111101);
    @(negedge clk);
    chk("post_rst_beat0_m", bus_m.out_data, 3'b111);
    chk("post_rst_beat0_l", bus_l.out_data, 3'b101);
    wait_idle();

    // final report
    chk("exp_m_drained", exp_m.size(), 0);
    chk("exp_l_drained", exp_l.size(), 0);
    chk("accepted_m", acc_m, n_sent);
    chk("accepted_l", acc_l, n_sent);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
